// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
// Holds the FSM state encoding, the owner encoding and the grant-priority helper.
package mem_arb_pkg;

  localparam int MAX_DM_RUN_DEF = 4;
  // Wide enough for the full 1..15 run-limit range.
  localparam int RUN_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  typedef struct packed {
    owner_t      owner;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } xact_t;

  // Data port wins ties unless it has used up its run while fetch waits.
  function automatic logic pick_dm(input logic if_req, input logic dm_req, input logic at_max);
    return dm_req & ~(if_req & at_max);
  endfunction

endpackage

// File: rtl/arb_run_counter.sv
// Counts consecutive data-port grants taken while fetch is waiting.
// Saturates at MAX_RUN; clear takes priority over increment.
module arb_run_counter
  import mem_arb_pkg::*;
#(
  parameter int MAX_RUN = MAX_DM_RUN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [RUN_W-1:0] MAX_CNT = RUN_W'(MAX_RUN);
  localparam logic [RUN_W-1:0] ONE     = {{(RUN_W-1){1'b0}}, 1'b1};

  logic [RUN_W-1:0] cnt_r;

  // Run counter register: clear, saturating increment, or hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {RUN_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {RUN_W{1'b0}};
    end else if (inc && (cnt_r != MAX_CNT)) begin
      cnt_r <= cnt_r + ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign at_max = (cnt_r == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the instruction-fetch and data ports onto one shared memory port.
// One transaction in flight: IDLE grants, ISSUE presents it, WAIT collects read data.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_DM_RUN = MAX_DM_RUN_DEF,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  input  logic [3:0]        dm_wstrb,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [31:0]       dm_rdata,
  output logic              dm_wdone,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  arb_state_t        state_r;
  arb_state_t        state_s;
  xact_t             xact_r;
  logic [ADDR_W-1:0] addr_r;
  logic              at_max_s;
  logic              dm_pick_s;
  logic              if_gnt_s;
  logic              dm_gnt_s;
  logic              run_inc_s;
  logic              run_clr_s;

  // Grant decision; grants exist only in IDLE.
  always_comb begin
    dm_pick_s = pick_dm(if_req, dm_req, at_max_s);
    if (state_r == ST_IDLE) begin
      dm_gnt_s = dm_pick_s;
      if_gnt_s = if_req & ~dm_pick_s;
    end else begin
      dm_gnt_s = 1'b0;
      if_gnt_s = 1'b0;
    end
  end

  assign run_inc_s = dm_gnt_s & if_req;
  assign run_clr_s = if_gnt_s | ~if_req;

  arb_run_counter #(
    .MAX_RUN (MAX_DM_RUN)
  ) u_run_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (run_inc_s),
    .clr    (run_clr_s),
    .at_max (at_max_s)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (if_req || dm_req) begin
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (mem_ready) begin
          state_s = xact_r.we ? ST_IDLE : ST_WAIT;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Owner and payload capture at grant; fetch is always a plain read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xact_r <= '{owner: OWN_IF, we: 1'b0, wdata: 32'd0, wstrb: 4'd0};
      addr_r <= {ADDR_W{1'b0}};
    end else if (dm_gnt_s) begin
      xact_r <= '{owner: OWN_DM, we: dm_we, wdata: dm_wdata, wstrb: dm_wstrb};
      addr_r <= dm_addr;
    end else if (if_gnt_s) begin
      xact_r <= '{owner: OWN_IF, we: 1'b0, wdata: 32'd0, wstrb: 4'd0};
      addr_r <= if_addr;
    end else begin
      xact_r <= xact_r;
      addr_r <= addr_r;
    end
  end

  // Per-state outputs; read responses pass straight through to the owner.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    dm_wdone  = 1'b0;
    if_rvalid = 1'b0;
    dm_rvalid = 1'b0;
    case (state_r)
      ST_ISSUE: begin
        mem_req  = 1'b1;
        mem_we   = xact_r.we;
        dm_wdone = mem_ready & xact_r.we & (xact_r.owner == OWN_DM);
      end
      ST_WAIT: begin
        if_rvalid = mem_rvalid & (xact_r.owner == OWN_IF);
        dm_rvalid = mem_rvalid & (xact_r.owner == OWN_DM);
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  assign if_gnt    = if_gnt_s;
  assign dm_gnt    = dm_gnt_s;
  assign mem_addr  = addr_r;
  assign mem_wdata = xact_r.wdata;
  assign mem_wstrb = xact_r.wstrb;
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_wstrb;
  logic        dm_gnt, dm_rvalid, dm_wdone;
  logic [31:0] dm_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_DM_RUN(4), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_wdone(dm_wdone),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge; inputs change here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #2;
  endtask

  task automatic run_cnt_chk(input string tag, input logic [3:0] exp);
    chk(tag, 64'(dut.u_run_cnt.cnt_r), 64'(exp));
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = 32'd0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'd0; dm_wdata = 32'd0; dm_wstrb = 4'd0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    step(); step();
    settle();
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_gnts", 64'({if_gnt, dm_gnt}), 64'd0);
    chk("rst_payload", {mem_addr, mem_wdata}, 64'd0);
    chk("rst_we_strb", 64'({mem_we, mem_wstrb}), 64'd0);
    run_cnt_chk("rst_run_cnt", 4'd0);
    reset = 1'b0;

    // Lone fetch
    step();
    if_req = 1'b1; if_addr = 32'h100; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD0BAD;
    settle();
    chk("fetch_gnt", 64'({if_gnt, dm_gnt}), 64'b10);
    chk("idle_rvalid_ignored", 64'({if_rvalid, dm_rvalid}), 64'd0);
    step();
    if_req = 1'b0; mem_rvalid = 1'b0; mem_ready = 1'b1;
    settle();
    chk("fetch_issue_req", 64'({mem_req, mem_we, if_gnt}), 64'b100);
    chk("fetch_issue_addr", 64'(mem_addr), 64'h100);
    chk("fetch_wstrb", 64'(mem_wstrb), 64'd0);
    step();
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    settle();
    chk("fetch_rvalid", 64'({if_rvalid, dm_rvalid, mem_req}), 64'b100);
    chk("fetch_rdata", 64'(if_rdata), 64'hDEADBEEF);
    step();
    mem_rvalid = 1'b0;
    settle();
    chk("fetch_done", 64'({if_rvalid, mem_req, if_gnt}), 64'd0);

    // Simultaneous requests: data wins, fetch follows
    if_req = 1'b1; if_addr = 32'h140; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    settle();
    chk("both_dm_first", 64'({if_gnt, dm_gnt}), 64'b01);
    step();
    dm_req = 1'b0; mem_ready = 1'b1;
    settle();
    chk("both_dm_addr", 64'(mem_addr), 64'h200);
    chk("both_no_gnt_in_issue", 64'({if_gnt, dm_gnt}), 64'd0);
    run_cnt_chk("both_run_cnt1", 4'd1);
    step();
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    settle();
    chk("both_dm_rvalid", 64'({if_rvalid, dm_rvalid}), 64'b01);
    chk("both_dm_rdata", 64'(dm_rdata), 64'h12345678);
    step();
    mem_rvalid = 1'b0;
    settle();
    chk("both_if_next", 64'({if_gnt, dm_gnt}), 64'b10);
    step();
    if_req = 1'b0; mem_ready = 1'b1;
    settle();
    chk("both_if_addr", 64'(mem_addr), 64'h140);
    run_cnt_chk("both_run_cnt_clr", 4'd0);
    step();
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    settle();
    chk("both_if_rvalid", 64'({if_rvalid, dm_rvalid, if_rdata}), {30'd0, 2'b10, 32'hCAFEF00D});
    step();
    mem_rvalid = 1'b0;

    // Starvation: data held, fetch waits for four data grants
    if_req = 1'b1; if_addr = 32'h180; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h280;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("starve_dm_gnt%0d", i), 64'({if_gnt, dm_gnt}), 64'b01);
      step();
      mem_ready = 1'b1;
      settle();
      run_cnt_chk($sformatf("starve_cnt%0d", i), 4'(i + 1));
      step();
      mem_ready = 1'b0; mem_rvalid = 1'b1;
      step();
      mem_rvalid = 1'b0;
    end
    settle();
    chk("starve_if_gnt", 64'({if_gnt, dm_gnt}), 64'b10);
    step();
    if_req = 1'b0; mem_ready = 1'b1;
    settle();
    run_cnt_chk("starve_cnt_clr", 4'd0);
    chk("starve_if_addr", 64'(mem_addr), 64'h180);
    step();
    mem_ready = 1'b0; mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0; dm_req = 1'b0;

    // Store with memory accept delayed three cycles
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h304; dm_wdata = 32'hA5A50000; dm_wstrb = 4'b1000;
    settle();
    chk("store_gnt", 64'({if_gnt, dm_gnt}), 64'b01);
    step();
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0; dm_wstrb = 4'd0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("store_hold_ctl%0d", i), 64'({mem_req, mem_we, dm_wdone, mem_wstrb}), 64'b1101000);
      chk($sformatf("store_hold_data%0d", i), {mem_addr, mem_wdata}, {32'h304, 32'hA5A50000});
      step();
    end
    mem_ready = 1'b1;
    settle();
    chk("store_wdone", 64'({dm_wdone, dm_rvalid, if_rvalid}), 64'b100);
    step();
    mem_ready = 1'b0;
    settle();
    chk("store_back_idle", 64'({mem_req, dm_wdone, dm_rvalid}), 64'd0);

    // Reset while waiting for read data, then a late response
    if_req = 1'b1; if_addr = 32'h400;
    settle();
    chk("rstw_gnt", 64'(if_gnt), 64'd1);
    step();
    if_req = 1'b0; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    settle();
    chk("rstw_in_wait", 64'(dut.state_r), 64'(ST_WAIT));
    reset = 1'b1;
    settle();
    chk("rstw_abandon", 64'({mem_req, if_rvalid, mem_addr}), 64'd0);
    step();
    reset = 1'b0;
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
    settle();
    chk("rstw_late_rvalid", 64'({if_rvalid, dm_rvalid}), 64'd0);
    chk("rstw_state_idle", 64'(dut.state_r), 64'(ST_IDLE));
    step();
    mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h500;
    settle();
    chk("rstw_next_gnt", 64'({if_gnt, dm_gnt}), 64'b10);
    step();
    if_req = 1'b0; mem_ready = 1'b1;
    settle();
    chk("rstw_next_addr", 64'(mem_addr), 64'h500);
    step();
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h600D600D;
    settle();
    chk("rstw_next_rdata", 64'({if_rvalid, if_rdata}), {31'd0, 1'b1, 32'h600D600D});
    step();
    mem_rvalid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
